// File: rtl/prog_loader.sv
// prog_loader
// Streams a program image from a byte-wide host interface into instruction
// memory and holds the CPU at BASE_ADDR until the image is completely loaded.
//
// Stream format: 16-bit word count N (MSB first), then N 32-bit words, each
// sent MSB first. Each assembled word is written to BASE_ADDR + 4*idx.
//
// Handshake: a byte moves only on a rising clock edge where byte_valid and
// byte_ready are both 1. The host may hold byte_valid high for as long as it
// likes. byte_data is ignored on every other cycle. byte_ready is a registered
// function of the state, so the host never sees it change in mid-cycle.
//
// Ports
//   clock      : the single clock, rising edge
//   reset      : asynchronous, active-high
//   start      : begins a session from IDLE, DONE or ERR; ignored otherwise
//   byte_valid : the host is presenting byte_data
//   byte_data  : stream byte
//   byte_ready : the loader accepts byte_data this cycle
//   mem_we     : instruction-memory write strobe (exactly one cycle per word)
//   mem_addr   : word-aligned byte address; holds its last value between writes
//   mem_wdata  : assembled word; holds its last value between writes
//   cpu_hold   : holds the CPU program counter at BASE_ADDR; low only in DONE
//   done       : the load completed
//   err        : the load was aborted because the word count was illegal
//   state_dbg  : current FSM state encoding, for observation only
module prog_loader #(
    parameter int          MAX_WORDS = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        err,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CNT_HI = 3'd1,
        CNT_LO = 3'd2,
        WORD   = 3'd3,
        WRITE  = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } state_t;

    localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

    state_t      state;
    logic [15:0] n_words;
    logic [15:0] idx;
    logic [1:0]  byte_cnt;
    logic [31:0] asm_word;

    logic        xfer;
    logic [15:0] n_cand;
    logic [31:0] word_cand;
    logic [31:0] addr_cand;
    logic [15:0] idx_next;

    assign xfer      = byte_valid & byte_ready;
    assign n_cand    = {n_words[15:8], byte_data};
    assign word_cand = {asm_word[23:0], byte_data};
    // 32-bit address arithmetic: idx never exceeds MAX_WORDS, so no wrap.
    assign addr_cand = BASE_ADDR + {14'd0, idx, 2'b00};
    assign idx_next  = idx + 16'd1;
    assign state_dbg = state;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            n_words    <= 16'd0;
            idx        <= 16'd0;
            byte_cnt   <= 2'd0;
            asm_word   <= 32'd0;
            byte_ready <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= BASE_ADDR;
            mem_wdata  <= 32'd0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state      <= CNT_HI;
                        idx        <= 16'd0;
                        byte_cnt   <= 2'd0;
                        byte_ready <= 1'b1;
                        cpu_hold   <= 1'b1;
                        done       <= 1'b0;
                        err        <= 1'b0;
                    end
                end
                CNT_HI: begin
                    if (xfer) begin
                        n_words[15:8] <= byte_data;
                        state         <= CNT_LO;
                    end
                end
                CNT_LO: begin
                    if (xfer) begin
                        n_words[7:0] <= byte_data;
                        if (n_cand == 16'd0 || n_cand > MAX_N) begin
                            state      <= ERR;
                            byte_ready <= 1'b0;
                            err        <= 1'b1;
                        end else begin
                            state    <= WORD;
                            byte_cnt <= 2'd0;
                        end
                    end
                end
                WORD: begin
                    if (xfer) begin
                        asm_word <= word_cand;
                        if (byte_cnt == 2'd3) begin
                            // The write data is taken straight from the shift
                            // result so that WRITE follows the 4th byte immediately.
                            state      <= WRITE;
                            byte_ready <= 1'b0;
                            mem_we     <= 1'b1;
                            mem_addr   <= addr_cand;
                            mem_wdata  <= word_cand;
                            byte_cnt   <= 2'd0;
                        end else begin
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end
                end
                WRITE: begin
                    mem_we <= 1'b0;
                    idx    <= idx_next;
                    if (idx_next == n_words) begin
                        state    <= DONE;
                        cpu_hold <= 1'b0;
                        done     <= 1'b1;
                    end else begin
                        state      <= WORD;
                        byte_ready <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    byte_ready <= 1'b0;
                    mem_we     <= 1'b0;
                    cpu_hold   <= 1'b1;
                    done       <= 1'b0;
                    err        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader
// Directed bench for prog_loader: a table of load sessions, applied in a loop,
// plus hand-written sequences for the 64-word load, start while busy, and
// reset during a session.
module tb_prog_loader;

    localparam int          MAX_WORDS = 64;
    localparam logic [31:0] BASE_ADDR = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        err;
    logic [2:0]  state_dbg;

    prog_loader #(.MAX_WORDS(MAX_WORDS), .BASE_ADDR(BASE_ADDR)) dut (
        .clock(clock), .reset(reset), .start(start),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .done(done), .err(err), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // scoreboard
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Every write strobe is matched against the next expected {addr, data}.
    always @(negedge clock) begin
        if (reset === 1'b0 && mem_we === 1'b1) begin
            check("ready_low_in_write", 64'(byte_ready), 64'd0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0h data %0h, expected no write",
                         mem_addr, mem_wdata);
            end else begin
                check("write_addr_data", {mem_addr, mem_wdata}, exp_q.pop_front());
            end
        end
    end

    // driver tasks (all called at a falling edge, return at a falling edge)
    task automatic send_byte(input logic [7:0] b, input int gap_max);
        int gaps;
        int waited;
        gaps = (gap_max > 0) ? int'($urandom_range(gap_max, 1)) : 0;
        if (gaps > 0) begin
            byte_valid = 1'b0;
            repeat (gaps) @(negedge clock);
        end
        byte_valid = 1'b1;
        byte_data  = b;
        waited = 0;
        while (byte_ready !== 1'b1 && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        if (byte_ready !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL byte_timeout: byte %0h not accepted within 20 cycles", b);
        end
        @(negedge clock);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap_max);
        for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8], gap_max);
    endtask

    task automatic do_start(input string nm);
        byte_valid = 1'b0;
        start      = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check({nm, "_start_err"},   64'(err),        64'd0);
        check({nm, "_start_done"},  64'(done),       64'd0);
        check({nm, "_start_ready"}, 64'(byte_ready), 64'd1);
        check({nm, "_start_hold"},  64'(cpu_hold),   64'd1);
    endtask

    task automatic wait_done(input string nm);
        int waited;
        byte_valid = 1'b0;
        waited = 0;
        while (done !== 1'b1 && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        check({nm, "_done"},      64'(done),         64'd1);
        check({nm, "_hold"},      64'(cpu_hold),     64'd0);
        check({nm, "_err"},       64'(err),          64'd0);
        check({nm, "_ready"},     64'(byte_ready),   64'd0);
        check({nm, "_pending"},   64'(exp_q.size()), 64'd0);
    endtask

    typedef struct {
        string       name;
        logic [15:0] n;
        logic [31:0] w0;
        logic [31:0] w1;
        int          gap;
        logic        exp_err;
    } vec_t;

    vec_t tbl[7];

    task automatic run_vec(input vec_t v);
        do_start(v.name);
        send_byte(v.n[15:8], v.gap);
        send_byte(v.n[7:0], v.gap);
        if (v.exp_err) begin
            byte_valid = 1'b1;
            repeat (2) @(negedge clock);
            byte_valid = 1'b0;
            check({v.name, "_err"},   64'(err),          64'd1);
            check({v.name, "_hold"},  64'(cpu_hold),     64'd1);
            check({v.name, "_done"},  64'(done),         64'd0);
            check({v.name, "_ready"}, 64'(byte_ready),   64'd0);
            check({v.name, "_we"},    64'(mem_we),       64'd0);
        end else begin
            exp_q.push_back({BASE_ADDR, v.w0});
            if (v.n >= 16'd2) exp_q.push_back({BASE_ADDR + 32'd4, v.w1});
            send_word(v.w0, v.gap);
            if (v.n >= 16'd2) send_word(v.w1, v.gap);
            wait_done(v.name);
        end
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, "_ready"}, 64'(byte_ready), 64'd0);
        check({nm, "_we"},    64'(mem_we),     64'd0);
        check({nm, "_addr"},  64'(mem_addr),   64'(BASE_ADDR));
        check({nm, "_wdata"}, 64'(mem_wdata),  64'd0);
        check({nm, "_hold"},  64'(cpu_hold),   64'd1);
        check({nm, "_done"},  64'(done),       64'd0);
        check({nm, "_err"},   64'(err),        64'd0);
    endtask

    initial begin
        logic [31:0] w;

        tbl[0] = '{"normal",    16'h0002, 32'h2008_0005, 32'hAC08_0000, 0, 1'b0};
        tbl[1] = '{"zero_cnt",  16'h0000, 32'h0,         32'h0,         0, 1'b1};
        tbl[2] = '{"over_cnt",  16'h0041, 32'h0,         32'h0,         0, 1'b1};
        tbl[3] = '{"throttled", 16'h0002, 32'h2008_0005, 32'hAC08_0000, 3, 1'b0};
        tbl[4] = '{"max_cnt",   16'hFFFF, 32'h0,         32'h0,         0, 1'b1};
        tbl[5] = '{"hi_cnt",    16'h0100, 32'h0,         32'h0,         2, 1'b1};
        tbl[6] = '{"one_word",  16'h0001, 32'hDEAD_BEEF, 32'h0,         1, 1'b0};

        reset      = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (2) @(negedge clock);
        check_reset_outputs("in_reset");
        reset = 1'b0;
        byte_valid = 1'b1;
        repeat (3) @(negedge clock);
        check("idle_ready", 64'(byte_ready), 64'd0);
        check("idle_hold",  64'(cpu_hold),   64'd1);
        byte_valid = 1'b0;

        // table-driven sessions; each start also leaves the previous DONE/ERR
        for (int i = 0; i < 7; i++) run_vec(tbl[i]);

        // full-capacity load: the last write lands at 0xFC
        do_start("full");
        send_byte(8'h00, 0);
        send_byte(8'h40, 0);
        for (int i = 0; i < 64; i++) begin
            w = {8'(i), 8'hA5, 8'(63 - i), 8'(i * 4)};
            exp_q.push_back({BASE_ADDR + 32'(4 * i), w});
            send_word(w, 0);
        end
        wait_done("full");
        check("full_last_addr", 64'(mem_addr), 64'h0000_00FC);

        // start pulsed mid-word is ignored
        do_start("busy");
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        exp_q.push_back({BASE_ADDR, 32'h2008_0005});
        exp_q.push_back({BASE_ADDR + 32'd4, 32'hAC08_0000});
        send_byte(8'h20, 0);
        send_byte(8'h08, 0);
        byte_valid = 1'b0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("busy_err", 64'(err), 64'd0);
        send_byte(8'h00, 0);
        send_byte(8'h05, 0);
        send_word(32'hAC08_0000, 0);
        wait_done("busy");

        // reset after the 2nd byte of word 1: no write to 0x4
        do_start("rst_mid");
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        exp_q.push_back({BASE_ADDR, 32'h2008_0005});
        send_word(32'h2008_0005, 0);
        send_byte(8'hAC, 0);
        send_byte(8'h08, 0);
        #2 reset = 1'b1;
        #1 check_reset_outputs("rst_mid");
        check("rst_mid_pending", 64'(exp_q.size()), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        byte_valid = 1'b1;
        byte_data  = 8'h00;
        repeat (4) @(negedge clock);
        check("post_rst_ready", 64'(byte_ready), 64'd0);
        check("post_rst_hold",  64'(cpu_hold),   64'd1);
        byte_valid = 1'b0;
        run_vec(tbl[0]);

        // reset during the WRITE cycle drops the strobe at once
        do_start("rst_wr");
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        exp_q.push_back({BASE_ADDR, 32'h1234_5678});
        send_word(32'h1234_5678, 0);
        check("rst_wr_we_before", 64'(mem_we), 64'd1);
        #2 reset = 1'b1;
        #1 check_reset_outputs("rst_wr");
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        run_vec(tbl[6]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 64, meaning the instruction-memory capacity in 32-bit words.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the byte address of the first loaded word.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: level sampled each cycle; begins a load session.
REQ-006 SHALL have port byte_valid, input, 1 bit: the host presents byte_data.
REQ-007 SHALL have port byte_data, input, 8 bits: the stream byte.
REQ-008 SHALL have port byte_ready, output, 1 bit: the loader accepts byte_data this cycle.
REQ-009 SHALL have port mem_we, output, 1 bit: instruction-memory write strobe.
REQ-010 SHALL have port mem_addr, output, 32 bits: byte address, always word aligned.
REQ-011 SHALL have port mem_wdata, output, 32 bits: the instruction word to write.
REQ-012 SHALL have port cpu_hold, output, 1 bit: holds the pipeline PC at BASE_ADDR while high.
REQ-013 SHALL have port done, output, 1 bit: load completed successfully.
REQ-014 SHALL have port err, output, 1 bit: load aborted on a bad word count.

Function
REQ-015 The stream format SHALL be: 2-byte word count N (MSB first), then N words of 4 bytes each (MSB first).
REQ-016 A byte SHALL transfer only on a cycle where byte_valid=1 and byte_ready=1; the host may hold byte_valid high arbitrarily, and byte_data SHALL be ignored on all other cycles.
REQ-017 The FSM SHALL have states IDLE, CNT_HI, CNT_LO, WORD, WRITE, DONE and ERR.
REQ-018 From IDLE, DONE or ERR, start=1 SHALL go to CNT_HI, clear done, clear err, and clear the word index to 0.
REQ-019 In any other state, start SHALL be ignored.
REQ-020 CNT_HI SHALL go to CNT_LO on a transfer, latching N[15:8].
REQ-021 CNT_LO SHALL, on a transfer, latch N[7:0] and then:
- go to ERR if N==0 or N>MAX_WORDS;
- otherwise go to WORD with the byte counter at 0.
REQ-022 WORD SHALL shift each transferred byte into an assembly register, MSB first.
REQ-023 On the 4th byte, WORD SHALL go to WRITE on the next cycle.
REQ-024 WRITE SHALL last exactly 1 cycle with mem_we=1, mem_addr=BASE_ADDR+4*idx and mem_wdata=the assembled word.
REQ-025 After WRITE, idx SHALL increment; the FSM SHALL go to DONE if idx==N, else back to WORD.
REQ-026 byte_ready SHALL be 1 only in CNT_HI, CNT_LO and WORD, and SHALL be 0 in IDLE, WRITE, DONE and ERR, so back-to-back bytes stall for one cycle per word.
REQ-027 mem_we SHALL be 1 only in WRITE; mem_addr and mem_wdata SHALL hold their last values otherwise.
REQ-028 cpu_hold SHALL be 0 only in DONE, and 1 in all other states, including ERR.
REQ-029 done SHALL be 1 exactly while in DONE; err SHALL be 1 exactly while in ERR.
REQ-030 idx SHALL be 16 bits wide and SHALL never exceed MAX_WORDS; the address arithmetic SHALL be 32-bit, with no wrap for legal N.
REQ-031 Word latency SHALL be: mem_we asserts the cycle after the 4th byte transfer; the minimum session is 2+5N cycles of byte_valid=1 after CNT_HI is entered.

Reset
REQ-032 reset=1 SHALL immediately (asynchronously) force:
- state IDLE, idx=0, N=0, byte counter 0, assembly register 0;
- byte_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0;
- cpu_hold=1, done=0, err=0.
REQ-033 Reset asserted mid-session SHALL abort the session with no further write; memory contents already written are not restored.
REQ-034 After reset deasserts, the FSM SHALL remain in IDLE until start=1.

Verification
REQ-035 The bench SHALL cover a normal load: start, then bytes 00 02 20 08 00 05 AC 08 00 00 with byte_valid held high.
- Required writes: mem_we pulses at addr 0x0 with data 0x20080005, then at addr 0x4 with data 0xAC080000.
- Then done=1 and cpu_hold=0.
REQ-036 The bench SHALL cover a zero count: bytes 00 00.
- Required: err=1, cpu_hold=1, no mem_we pulse, byte_ready=0.
- A subsequent start SHALL clear err and reach CNT_HI.
REQ-037 The bench SHALL cover an overflow count: MAX_WORDS=64 with bytes 00 41.
- Required: err=1 with no write.
- Count 00 40 followed by 256 data bytes SHALL end with the last write at addr 0xFC and done=1.
REQ-038 The bench SHALL cover a throttled host: byte_valid toggling 1,0,1,0 with random gaps.
- Required: identical writes to REQ-035, with no byte lost or duplicated.
- byte_ready SHALL be 0 during each WRITE cycle.
REQ-039 The bench SHALL cover reset mid-word: assert reset after the 2nd byte of word 1 (N=2).
- Required: mem_we drops immediately; outputs take the REQ-032 values; no write to addr 0x4.
- A fresh session SHALL load correctly.
REQ-040 The bench SHALL cover start while busy: pulse start during WORD.
- Required: the session continues unchanged; idx is not cleared.
